tqvp_htfab_vga_grabber: RTL
===========================

TQVP_HTFAB_VGA_GRABBER -- requirements
Module: tqvp_htfab_vga_grabber

Interface
REQ-001 SHALL have port clk, input, 1: project clock, 64 MHz nominal; sole clock.
REQ-002 SHALL have port rst_n, input, 1: reset; synchronous, active-low.
REQ-003 SHALL have port ui_in, input, 8: ui_in[0] pixel, ui_in[1] hsync (active-low), ui_in[2] vsync (active-low); other bits unused; already synchronized externally.
REQ-004 SHALL have port uo_out, output, 8: {5'b0, sample_strobe, busy, 1'b0}; bit0 kept 0 for UART TX.
REQ-005 SHALL have port address, input, 6: register/row select.
REQ-006 SHALL have port data_in, input, 32: write data.
REQ-007 SHALL have port data_write_n, input, 2: 11 none, 00 8-bit, 01 16-bit, 10 32-bit.
REQ-008 SHALL have port data_read_n, input, 2: same encoding, for reads.
REQ-009 SHALL have port data_out, output, 32: registered read data.
REQ-010 SHALL have port data_ready, output, 1: read-complete strobe.
REQ-011 SHALL have port user_interrupt, output, 1: frame-captured interrupt.

Function
REQ-012 SHALL capture a 32x16 1-bit frame into 16 row registers of 32 bits; row bit i = pixel column i (bit0 leftmost).
REQ-013 SHALL decode 8-bit writes: addr 0 CTRL, 1 H_OFFSET, 2 PIX_DIV, 3 V_OFFSET, 4 LINE_DIV; other addresses and all 16/32-bit writes ignored.
REQ-014 CTRL SHALL be: bit0 arm (clear done, clear interrupt, reset row index to 0, enter WAIT_VSYNC), bit1 continuous, bit7 abort (enter IDLE; wins over bit0).
REQ-015 SHALL detect edges as falling (previous sample 1, current 0) on hsync and vsync, one cycle after the input transition.
REQ-016 SHALL implement states IDLE, WAIT_VSYNC, WAIT_LINE, H_SKIP, SAMPLE, DONE.
REQ-017 WAIT_VSYNC: on vsync edge, load line_cnt=V_OFFSET, go WAIT_LINE.
REQ-018 WAIT_LINE: on hsync edge, if line_cnt==0 load line_cnt=LINE_DIV, load h_cnt=4*H_OFFSET, go H_SKIP; else decrement line_cnt.
REQ-019 H_SKIP: decrement h_cnt each cycle; on h_cnt==0 load div_cnt=0, go SAMPLE.
REQ-020 SAMPLE: when div_cnt==0 latch ui_in[0] into bit col, pulse sample_strobe 1 cycle, reload div_cnt=PIX_DIV, increment col; otherwise decrement div_cnt.
REQ-021 After col 31 sampled: commit row to row register, increment row index; row 16 -> DONE, else WAIT_LINE.
REQ-022 Hsync edge during H_SKIP or SAMPLE SHALL commit the partial row (unsampled bits 0), advance row index, and process the edge as in WAIT_LINE in the same cycle.
REQ-023 Vsync edge in WAIT_LINE/H_SKIP/SAMPLE SHALL discard the partial row, reset row index to 0, and restart as in WAIT_VSYNC.
REQ-024 Entering DONE SHALL set done and assert user_interrupt; it holds until CTRL arm or abort.
REQ-025 busy SHALL be 1 in any state except IDLE and DONE.
REQ-026 A 32-bit read SHALL return row address[5:2]; an 8-bit read SHALL return {24'b0, row_index[3:0], 2'b0, done, busy}; a 16-bit read SHALL return 0.
REQ-027 data_ready SHALL pulse high exactly 1 cycle, the cycle after any read request, with data_out valid in that cycle; back-to-back requests each get a strobe.
REQ-028 A row commit and CPU read of the same row in one cycle SHALL return the pre-commit value.

Reset
REQ-029 On rst_n low at clk edge: state IDLE, rows 0, row index 0, done 0, user_interrupt 0, data_ready 0, data_out 0, uo_out 0, continuous 0.
REQ-030 Reset values SHALL be: H_OFFSET 92, PIX_DIV 50, V_OFFSET 35, LINE_DIV 29.

Configuration
REQ-031 Macro VGA_GRABBER_CONTINUOUS_EN defined: DONE with continuous=1 SHALL set done/interrupt and move to WAIT_VSYNC next cycle with row index 0.
REQ-032 Macro undefined: CTRL bit1 SHALL be ignored, always 0; DONE holds until CTRL write.

Verification
REQ-033 Reset, 8-bit read addr 0 -> data_out 0x00, data_ready 1 cycle after request.
REQ-034 Program H_OFFSET 1, PIX_DIV 1, V_OFFSET 0, LINE_DIV 0, arm; drive frame with pixel = column parity -> all rows 0xAAAAAAAA, user_interrupt 1.
REQ-035 Same config, vsync edge after 5 rows -> row index 0, capture restarts, final frame complete and correct.
REQ-036 Hsync edge at column 10 of row 3 -> row 3 bits 31:10 = 0, row index 4.
REQ-037 Abort during SAMPLE -> busy 0, state IDLE, user_interrupt 0; continuous set with macro -> second frame captured without re-arm.

Source files
------------

// File: rtl/tqvp_htfab_vga_grabber.sv
// tqvp_htfab_vga_grabber -- 32x16 one-bit VGA frame grabber peripheral.
//
// Watches an externally synchronised VGA stream (pixel, hsync, vsync) and
// samples a 32x16 window of 1-bit pixels into 16 row registers that the CPU
// reads back over the peripheral bus.
//
// Ports
//   clk            project clock (64 MHz nominal), sole clock
//   rst_n          synchronous active-low reset
//   ui_in          [0] pixel, [1] hsync (active-low), [2] vsync (active-low)
//   uo_out         {5'b0, sample_strobe, busy, 1'b0}; bit0 left free for UART TX
//   address        register select (writes) / row select address[5:2] (reads)
//   data_in        write data
//   data_write_n   11 none, 00 8-bit, 01 16-bit, 10 32-bit
//   data_read_n    same encoding, for reads
//   data_out       registered read data
//   data_ready     one-cycle strobe the cycle after any read request
//   user_interrupt high once a frame has been captured
//
// 8-bit write registers: 0 CTRL (bit0 arm, bit1 continuous, bit7 abort),
// 1 H_OFFSET, 2 PIX_DIV, 3 V_OFFSET, 4 LINE_DIV.
//
// Build option: define VGA_GRABBER_CONTINUOUS_EN to honour CTRL bit1, which
// re-arms capture automatically after every completed frame.

module tqvp_htfab_vga_grabber (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_VSYNC = 3'd1;
  localparam logic [2:0] S_WAIT_LINE  = 3'd2;
  localparam logic [2:0] S_H_SKIP     = 3'd3;
  localparam logic [2:0] S_SAMPLE     = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]  state;
  logic [7:0]  h_offset;
  logic [7:0]  pix_div;
  logic [7:0]  v_offset;
  logic [7:0]  line_div;
  logic        hs_prev;
  logic        vs_prev;
  logic [7:0]  line_cnt;
  logic [9:0]  h_cnt;
  logic [7:0]  div_cnt;
  logic [4:0]  col;
  logic [31:0] row_buf;
  logic [4:0]  row_idx;
  logic        done;
  logic        sample_strobe;
  logic [31:0] rows [16];

`ifdef VGA_GRABBER_CONTINUOUS_EN
  logic        continuous;
`endif

  logic        pixel;
  logic        hs_fall;
  logic        vs_fall;
  logic        wr8;
  logic        ctrl_wr;
  logic        ctrl_act;
  logic        busy;
  logic        in_line;
  logic        commit_en;
  logic [31:0] commit_data;
  logic        unused_bits;

  assign pixel    = ui_in[0];
  assign hs_fall  = hs_prev & ~ui_in[1];
  assign vs_fall  = vs_prev & ~ui_in[2];
  assign wr8      = (data_write_n == 2'b00);
  assign ctrl_wr  = wr8 && (address == 6'd0);
  assign ctrl_act = ctrl_wr && (data_in[7] || data_in[0]);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign in_line  = (state == S_H_SKIP) || (state == S_SAMPLE);

  assign uo_out         = {5'b0, sample_strobe, busy, 1'b0};
  assign user_interrupt = done;
  assign unused_bits    = ^{ui_in[7:3], data_in[31:8], data_in[6:1]};

  // A row is committed either when column 31 is sampled (the final pixel is
  // merged in on the way to the row register) or when hsync cuts the line
  // short. A vsync edge or a CTRL arm/abort in the same cycle discards it.
  always_comb begin
    commit_en   = 1'b0;
    commit_data = row_buf;
    if (!ctrl_act && in_line && !vs_fall) begin
      if (hs_fall) begin
        commit_en = 1'b1;
      end else if (state == S_SAMPLE && div_cnt == '0 && col == 5'd31) begin
        commit_en   = 1'b1;
        commit_data = {pixel, row_buf[30:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) rows[i] <= '0;
    end else if (commit_en) begin
      rows[row_idx[3:0]] <= commit_data;
    end
  end

  // Read port: registered, so a commit and a read of the same row in one
  // cycle returns the pre-commit contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= (data_read_n != 2'b11);
      case (data_read_n)
        2'b10:   data_out <= rows[address[5:2]];
        2'b00:   data_out <= {24'b0, row_idx[3:0], 2'b0, done, busy};
        2'b01:   data_out <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      h_offset      <= 8'd92;
      pix_div       <= 8'd50;
      v_offset      <= 8'd35;
      line_div      <= 8'd29;
      hs_prev       <= 1'b1;
      vs_prev       <= 1'b1;
      line_cnt      <= '0;
      h_cnt         <= '0;
      div_cnt       <= '0;
      col           <= '0;
      row_buf       <= '0;
      row_idx       <= '0;
      done          <= 1'b0;
      sample_strobe <= 1'b0;
`ifdef VGA_GRABBER_CONTINUOUS_EN
      continuous    <= 1'b0;
`endif
    end else begin
      hs_prev       <= ui_in[1];
      vs_prev       <= ui_in[2];
      sample_strobe <= 1'b0;

      if (wr8) begin
        case (address)
          6'd1:    h_offset <= data_in[7:0];
          6'd2:    pix_div  <= data_in[7:0];
          6'd3:    v_offset <= data_in[7:0];
          6'd4:    line_div <= data_in[7:0];
          default: ;
        endcase
      end

`ifdef VGA_GRABBER_CONTINUOUS_EN
      if (ctrl_wr) continuous <= data_in[1];
`endif

      if (commit_en) row_idx <= row_idx + 5'd1;

      if (ctrl_act) begin
        done <= 1'b0;
        if (data_in[7]) begin
          state <= S_IDLE;
        end else begin
          row_idx <= '0;
          state   <= S_WAIT_VSYNC;
        end
      end else begin
        case (state)
          S_WAIT_VSYNC: begin
            if (vs_fall) begin
              line_cnt <= v_offset;
              state    <= S_WAIT_LINE;
            end
          end

          // An hsync edge mid-line has already committed the partial row via
          // commit_en; the same edge then also starts the next line here.
          S_WAIT_LINE, S_H_SKIP, S_SAMPLE: begin
            if (vs_fall) begin
              row_idx  <= '0;
              line_cnt <= v_offset;
              state    <= S_WAIT_LINE;
            end else if (hs_fall) begin
              if (in_line && row_idx == 5'd15) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else if (line_cnt == '0) begin
                line_cnt <= line_div;
                h_cnt    <= {h_offset, 2'b00};
                col      <= '0;
                row_buf  <= '0;
                state    <= S_H_SKIP;
              end else begin
                line_cnt <= line_cnt - 8'd1;
                state    <= S_WAIT_LINE;
              end
            end else if (state == S_H_SKIP) begin
              if (h_cnt == '0) begin
                div_cnt <= '0;
                state   <= S_SAMPLE;
              end else begin
                h_cnt <= h_cnt - 10'd1;
              end
            end else if (state == S_SAMPLE) begin
              if (div_cnt == '0) begin
                row_buf[col]  <= pixel;
                sample_strobe <= 1'b1;
                div_cnt       <= pix_div;
                col           <= col + 5'd1;
                if (col == 5'd31) begin
                  if (row_idx == 5'd15) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                  end else begin
                    state <= S_WAIT_LINE;
                  end
                end
              end else begin
                div_cnt <= div_cnt - 8'd1;
              end
            end
          end

`ifdef VGA_GRABBER_CONTINUOUS_EN
          S_DONE: begin
            if (continuous) begin
              row_idx <= '0;
              state   <= S_WAIT_VSYNC;
            end
          end
`endif

          default: ;
        endcase
      end
    end
  end

endmodule
